// File: rtl/pfb_synth_pkg.sv
`default_nettype none
// ============================================================
// Module  : pfb_synth_pkg
// Purpose : shared types and arithmetic for the synthesis combiner
// Rev     : 1.0
// ============================================================
package pfb_synth_pkg;

  localparam int DEF_N = 32;
  localparam int DEF_L = 4;

  typedef struct packed {
    logic signed [15:0] q;
    logic signed [15:0] i;
  } iq16_t;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic int frame_len(input int n, input int l);
    return n / (2 * l);
  endfunction

  function automatic logic signed [15:0] sat_add16(input logic signed [16:0] sum);
    if (sum > 17'sd32767) return 16'sh7fff;
    if (sum < -17'sd32768) return 16'sh8000;
    return sum[15:0];
  endfunction

  // I and Q saturate independently; operands are sign-extended to 17 bits.
  function automatic iq16_t iq_add(input iq16_t a, input iq16_t b);
    logic signed [16:0] ai, bi, aq, bq;
    iq16_t r;
    ai = {a.i[15], a.i};
    bi = {b.i[15], b.i};
    aq = {a.q[15], a.q};
    bq = {b.q[15], b.q};
    r.i = sat_add16(ai + bi);
    r.q = sat_add16(aq + bq);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pfb_delay_ram.sv
`default_nettype none
// ============================================================
// Module  : pfb_delay_ram
// Purpose : simple dual-port RAM, registered read, read-before-write
// Rev     : 1.0
// ============================================================
module pfb_delay_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Both accesses use NBAs, so a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/pfb_synth_combiner.sv
`default_nettype none
// ============================================================
// Module  : pfb_synth_combiner
// Purpose : overlap-add of framed 2L-lane synthesis FIR outputs
// Rev     : 1.0
// ============================================================
module pfb_synth_combiner
  import pfb_synth_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int L = DEF_L
) (
  input  logic              aclk,
  input  logic              areset,
  output logic              s_axis_tready,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic [2*L*32-1:0] s_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic [L*32-1:0]   m_axis_tdata,
  output logic              locked,
  output logic              err_tlast_missing,
  output logic              err_tlast_unexpected
);

  localparam int F  = frame_len(N, L);
  localparam int CW = (F > 1) ? $clog2(F) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(F - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            at_end, in_frame, bad_unexp, bad_miss, accept;
  logic [L*32-1:0] lower_w, upper_w, ram_rdata, sum_w;
  logic            s1_valid_q, s1_last_q;
  logic [L*32-1:0] s1_lower_q, m_data_q;
  logic            m_valid_q, m_last_q, locked_q, err_miss_q, err_unexp_q;

  assign lower_w   = s_axis_tdata[L*32-1:0];
  assign upper_w   = s_axis_tdata[2*L*32-1:L*32];
  assign at_end    = (cnt_q == LAST_BEAT);
  assign in_frame  = s_axis_tvalid && (state_q != SYNC);
  assign bad_unexp = in_frame && s_axis_tlast && !at_end;
  assign bad_miss  = in_frame && !s_axis_tlast && at_end;
  assign accept    = s_axis_tvalid && (state_q == RUN) && !bad_unexp && !bad_miss;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (s_axis_tvalid) begin
      unique case (state_q)
        SYNC: begin
          if (s_axis_tlast) begin
            state_d = PRIME;
            cnt_d   = '0;
          end
        end
        PRIME, RUN: begin
          if (bad_unexp || bad_miss) begin
            state_d = SYNC;
            cnt_d   = '0;
          end else begin
            cnt_d = at_end ? '0 : cnt_q + 1'b1;
            if (at_end) state_d = RUN;
          end
        end
        default: begin
          state_d = SYNC;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The upper half is stored during PRIME and RUN, and read back one frame later.
  pfb_delay_ram #(
    .DEPTH (F),
    .WIDTH (L*32)
  ) u_ram (
    .clk     (aclk),
    .we_i    (in_frame),
    .waddr_i (cnt_q),
    .wdata_i (upper_w),
    .re_i    (accept),
    .raddr_i (cnt_q),
    .rdata_o (ram_rdata)
  );

  for (genvar i = 0; i < L; i++) begin : g_lane
    iq16_t lo, hi;
    assign lo = s1_lower_q[i*32 +: 32];
    assign hi = ram_rdata[i*32 +: 32];
    assign sum_w[i*32 +: 32] = iq_add(lo, hi);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= SYNC;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      locked_q    <= 1'b0;
      err_miss_q  <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= accept;
      s1_last_q   <= at_end;
      m_valid_q   <= s1_valid_q;
      m_last_q    <= s1_valid_q && s1_last_q;
      if (s1_valid_q) m_data_q <= sum_w;
      locked_q    <= (state_d == RUN);
      err_miss_q  <= bad_miss;
      err_unexp_q <= bad_unexp;
    end
  end

  // Datapath-only register: qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge aclk) begin
    if (accept) s1_lower_q <= lower_w;
  end

  assign s_axis_tready        = 1'b1;
  assign m_axis_tvalid        = m_valid_q;
  assign m_axis_tlast         = m_last_q;
  assign m_axis_tdata         = m_data_q;
  assign locked               = locked_q;
  assign err_tlast_missing    = err_miss_q;
  assign err_tlast_unexpected = err_unexp_q;

endmodule
`default_nettype wire

// File: tb/tb_pfb_synth_combiner.sv
`default_nettype none
// ============================================================
// Module  : tb_pfb_synth_combiner
// Purpose : self-checking bench, frame-level reference model
// Rev     : 1.0
// ============================================================
module tb_pfb_synth_combiner;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, vin, lin, sel;
  logic [255:0] din;
  logic         v0, v1;
  assign v0 = vin & ~sel;
  assign v1 = vin & sel;

  logic         rdy0, mv0, ml0, lk0, em0, eu0;
  logic [127:0] md0;
  logic         rdy1, mv1, ml1, lk1, em1, eu1;
  logic [63:0]  md1;

  pfb_synth_combiner #(.N(32), .L(4)) dut0 (
    .aclk(clk), .areset(rst), .s_axis_tready(rdy0), .s_axis_tvalid(v0),
    .s_axis_tlast(lin), .s_axis_tdata(din), .m_axis_tvalid(mv0),
    .m_axis_tlast(ml0), .m_axis_tdata(md0), .locked(lk0),
    .err_tlast_missing(em0), .err_tlast_unexpected(eu0));

  pfb_synth_combiner #(.N(64), .L(2)) dut1 (
    .aclk(clk), .areset(rst), .s_axis_tready(rdy1), .s_axis_tvalid(v1),
    .s_axis_tlast(lin), .s_axis_tdata(din[127:0]), .m_axis_tvalid(mv1),
    .m_axis_tlast(ml1), .m_axis_tdata(md1), .locked(lk1),
    .err_tlast_missing(em1), .err_tlast_unexpected(eu1));

  logic         o_ready, o_valid, o_last, o_lock, o_em, o_eu;
  logic [127:0] o_data;
  assign o_ready = sel ? rdy1 : rdy0;
  assign o_valid = sel ? mv1 : mv0;
  assign o_last  = sel ? ml1 : ml0;
  assign o_lock  = sel ? lk1 : lk0;
  assign o_em    = sel ? em1 : em0;
  assign o_eu    = sel ? eu1 : eu0;
  assign o_data  = sel ? {64'b0, md1} : md0;

  // Reference model: phase 0 = hunting for tlast, 1 = filling history, 2 = producing.
  typedef struct {
    int           due;
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] hist [0:63][0:3];
  int          cur_L, cur_F, phase, beat, cyc, errors, checks;
  logic        exp_em, exp_eu, exp_lock;

  function automatic logic [15:0] sat16(input int a, input int b);
    int s;
    s = a + b;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  function automatic logic [255:0] mk(input int li, input int lq, input int ui, input int uq);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < cur_L; k++) begin
      d[k*32 +: 32]         = {lq[15:0], li[15:0]};
      d[(cur_L+k)*32 +: 32] = {uq[15:0], ui[15:0]};
    end
    return d;
  endfunction

  function automatic logic [255:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_step();
    logic [31:0] lo, hi;
    exp_t        e;
    exp_em = 1'b0;
    exp_eu = 1'b0;
    if (rst) begin
      phase = 0;
      beat  = 0;
      expq.delete();
    end else if (vin) begin
      if (phase == 0) begin
        if (lin) begin
          phase = 1;
          beat  = 0;
        end
      end else if (lin && beat != cur_F - 1) begin
        exp_eu = 1'b1;
        phase  = 0;
        beat   = 0;
      end else if (!lin && beat == cur_F - 1) begin
        exp_em = 1'b1;
        phase  = 0;
        beat   = 0;
      end else begin
        if (phase == 2) begin
          e.due  = cyc + 1;
          e.data = '0;
          e.last = (beat == cur_F - 1);
          for (int k = 0; k < cur_L; k++) begin
            lo = din[k*32 +: 32];
            hi = hist[beat][k];
            e.data[k*32 +: 16]      = sat16($signed(lo[15:0]), $signed(hi[15:0]));
            e.data[k*32 + 16 +: 16] = sat16($signed(lo[31:16]), $signed(hi[31:16]));
          end
          expq.push_back(e);
        end
        for (int k = 0; k < cur_L; k++) hist[beat][k] = din[(cur_L+k)*32 +: 32];
        if (beat == cur_F - 1) begin
          beat  = 0;
          phase = 2;
        end else begin
          beat++;
        end
      end
    end
    exp_lock = (phase == 2);
  endtask

  task automatic check_outputs(input logic r);
    logic ev;
    exp_t h;
    ev = (expq.size() > 0) && (expq[0].due == cyc);
    chk("tvalid", 128'(o_valid), 128'(ev));
    if (ev) begin
      h = expq.pop_front();
      chk("tdata", o_data, h.data);
      chk("tlast", 128'(o_last), 128'(h.last));
    end
    chk("locked", 128'(o_lock), 128'(exp_lock));
    chk("err_missing", 128'(o_em), 128'(exp_em));
    chk("err_unexpected", 128'(o_eu), 128'(exp_eu));
    if (r) begin
      chk("reset_tdata", o_data, 128'(0));
      chk("reset_tlast", 128'(o_last), 128'(0));
    end
  endtask

  task automatic tick(input logic r, input logic v, input logic l, input logic [255:0] d);
    rst = r;
    vin = v;
    lin = l;
    din = d;
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check_outputs(r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic rand_frames(input int nf, input int maxgap);
    for (int f = 0; f < nf; f++)
      for (int b = 0; b < cur_F; b++) begin
        idle($urandom_range(maxgap, 0));
        tick(1'b0, 1'b1, b == cur_F - 1, rnd());
      end
  endtask

  task automatic lockup(input int nf);
    tick(1'b0, 1'b1, 1'b0, rnd());
    tick(1'b0, 1'b1, 1'b1, rnd());
    for (int f = 0; f < nf; f++)
      for (int b = 0; b < cur_F; b++)
        tick(1'b0, 1'b1, b == cur_F - 1, mk(b, 0, 100 + f*10 + b, 0));
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; phase = 0; beat = 0;
    sel = 1'b0; cur_L = 4; cur_F = 4;
    rst = 1'b1; vin = 1'b0; lin = 1'b0; din = '0;
    exp_em = 1'b0; exp_eu = 1'b0; exp_lock = 1'b0;
    @(negedge clk);
    tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, '0);
    chk("tready", 128'(o_ready), 128'(1));

    // Lock-up: garbage, tlast, one priming frame and three producing frames.
    lockup(4);
    idle(2);

    // Saturation corners, history frame then the frame that adds to it.
    tick(1'b0, 1'b1, 1'b0, mk(0, 0, 10000, -10000));
    tick(1'b0, 1'b1, 1'b0, mk(0, 0, 1, 0));
    tick(1'b0, 1'b1, 1'b0, mk(0, 0, -20000, 20000));
    tick(1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0));
    tick(1'b0, 1'b1, 1'b0, mk(30000, -30000, 7, 7));
    tick(1'b0, 1'b1, 1'b0, mk(-1, 0, 7, 7));
    tick(1'b0, 1'b1, 1'b0, mk(-20000, 20000, 7, 7));
    tick(1'b0, 1'b1, 1'b1, mk(5, -5, 7, 7));

    // Random data with random idle gaps.
    rand_frames(6, 3);

    // Unexpected tlast on beat 1, then garbage, resync, prime, produce.
    tick(1'b0, 1'b1, 1'b0, rnd());
    tick(1'b0, 1'b1, 1'b1, rnd());
    idle(3);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, rnd());
    tick(1'b0, 1'b1, 1'b1, rnd());
    rand_frames(2, 0);

    // Missing tlast on beat 3, then resync.
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, rnd());
    tick(1'b0, 1'b1, 1'b0, rnd());
    tick(1'b0, 1'b1, 1'b1, rnd());
    rand_frames(2, 1);

    // Reset at beat 2 of a producing frame.
    tick(1'b0, 1'b1, 1'b0, rnd());
    tick(1'b0, 1'b1, 1'b0, rnd());
    tick(1'b1, 1'b1, 1'b0, rnd());
    idle(2);
    tick(1'b0, 1'b1, 1'b1, rnd());
    rand_frames(2, 1);
    idle(3);

    // Second geometry: N=64, L=2, F=16.
    sel = 1'b1; cur_L = 2; cur_F = 16;
    tick(1'b1, 1'b0, 1'b0, '0);
    lockup(3);
    rand_frames(2, 2);
    idle(3);

    chk("queue_empty", 128'(expq.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pfb_synth_combiner.md
Name: pfb_synth_combiner

Overview:
- Synthesis-side counterpart of the analysis FIR bank.
- Consumes framed 2L-lane FIR outputs, frame length F = N/(2L) beats, with tlast on the last beat of each frame.
- Produces L lanes of overlap-added samples: out lane i = lower half lane i (current) + upper half lane i delayed by F valid beats. This undoes the half-bank time advance applied on the analysis side.
- Sits between the synthesis FIR bank and the output DAC lane interface.

Parameters:
- N, 32: number of channels; must be a multiple of 2L, and F = N/(2L) >= 2.
- L, 4: output lanes; input carries 2L lanes.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- s_axis_tready  out  1  always 1 (block never back-pressures).
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tlast  in  1  last beat of an F-beat frame.
- s_axis_tdata  in  2*L*32  lane k at [k*32 +: 32]; each lane is {Q[31:16], I[15:0]}, signed 16-bit. Lanes 0..L-1 are the lower half; L..2L-1 are the upper half.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tlast  out  1  last beat of output frame.
- m_axis_tdata  out  L*32  lane i at [i*32 +: 32], same I/Q packing.
- locked  out  1  high while in RUN.
- err_tlast_missing  out  1  one-cycle pulse: no tlast on beat F-1.
- err_tlast_unexpected  out  1  one-cycle pulse: tlast on beat < F-1.

Behaviour:
- Reset (areset=1 at a clock edge):
  - state=SYNC; beat counter=0.
  - m_axis_tvalid, m_axis_tlast, m_axis_tdata, locked, and both err pulses = 0.
  - Delay-line contents are don't-care, but are never emitted before PRIME completes.
  - Reset mid-frame discards the partial frame and any in-flight pipeline beats.
- Counting: the beat counter cnt (0..F-1) advances only on s_axis_tvalid=1. Idle cycles freeze all state, and the pipeline emits nothing for them.
- FSM:
  - SYNC: discard beats. A valid beat with tlast=1 goes to PRIME with cnt=0; the next valid beat is frame beat 0.
  - PRIME: write the upper half of each beat into delay RAM[cnt]; no output. On the valid beat with cnt=F-1 and tlast=1, go to RUN.
  - RUN: for each valid beat, read RAM[cnt] (the upper half from the previous frame, same beat index), then write the current upper half to RAM[cnt]. Read-before-write on the same address in the same cycle returns the OLD data.
- Framing check, applied in PRIME and RUN:
  - tlast=1 with cnt<F-1: pulse err_tlast_unexpected, go to SYNC. That beat is not emitted, and beats already in the pipeline still drain.
  - tlast=0 with cnt=F-1: pulse err_tlast_missing, go to SYNC, same drain rule.
  - The error-pulse cycle is the one after the offending beat.
- Arithmetic:
  - I and Q are added independently: 16b + 16b to a 17b sum, saturated to [-32768, 32767].
  - No scaling and no rounding.
- Latency:
  - Exactly 2 cycles from input beat to output: stage 1 registers the lower half, RAM read data, and cnt==F-1; stage 2 registers the saturated sum.
  - m_axis_tlast = registered (cnt==F-1) of the source beat.
  - m_axis_tvalid mirrors the s_axis_tvalid of RUN-accepted beats, delayed 2 cycles.
- locked = (state==RUN), registered.
- No m_axis_tready: downstream must always accept.

Decomposition:
- Package pfb_synth_pkg:
  - typedef iq16_t {Q, I}.
  - state enum {SYNC, PRIME, RUN}.
  - function sat_add16 (17b sum to 16b saturate).
  - localparam helper F = N/(2*L).
- Sub-module pfb_delay_ram: F-deep × L*32-bit simple dual-port RAM with registered read and read-before-write semantics. Inferred; distributed or block RAM chosen by the tool.

Test Plan:
- Lock-up, default N=32/L=4 (F=4): 1 garbage beat; tlast beat; 4 frames, with lower lanes = beat index and upper lanes = 100 + frame*10 + beat (I only, Q=0).
  - No output during frame 0 (PRIME); locked=1 after frame 0's tlast.
  - Frame 1 beat b output I = b + (100 + b) on every lane, appearing 2 cycles after its input.
  - m_axis_tlast on beats 3, 7, …
- Saturation: lower I=30000 with upper I=10000 gives 32767; lower Q=-30000 with upper Q=-10000 gives -32768; lower I=-1 with upper I=1 gives 0.
- tvalid gaps: insert 0–3 random idle cycles between beats.
  - Output sequence is identical to the gap-free run.
  - Each output lags its input by exactly 2 cycles, and no output appears in idle slots.
- Unexpected tlast on beat 1 while in RUN:
  - err_tlast_unexpected pulses once; locked drops.
  - At most 2 drained beats, then no output until a new tlast and a full PRIME frame.
- Missing tlast on beat 3: err_tlast_missing pulses once; the block resyncs on the next tlast, then PRIMEs and resumes correct sums.
- Reset mid-frame (areset high 1 cycle at beat 2 of RUN):
  - Next cycle all outputs = 0 and locked=0; no residual output from before reset.
  - Repeat with N=64, L=2 (F=16) for the lock-up and sum checks.
